// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Purpose : Shared constants for the likeALU operand sequencer: op encodings,
//           packed-instruction field offsets and the sequencer state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W      = 5;
  localparam int OP_W        = 2;
  localparam int INSTR_W     = 13;

  // Packed instruction layout: {use_acc[12], op[11:10], a[9:5], b[4:0]}
  localparam int USE_ACC_BIT = 12;
  localparam int OP_LSB      = 10;
  localparam int A_LSB       = 5;
  localparam int B_LSB       = 0;

  localparam logic [OP_W-1:0] OP_AND = 2'b00;
  localparam logic [OP_W-1:0] OP_ADD = 2'b01;
  localparam logic [OP_W-1:0] OP_OR  = 2'b10;
  localparam logic [OP_W-1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_instr_fifo.sv
`default_nettype none
// ============================================================================
// Module  : alu_instr_fifo
// Purpose : DEPTH-entry instruction FIFO with occupancy count.
// Ports   : clk, rst        clock / async active-high reset
//           push_i, data_i  write request (ignored while full)
//           pop_i, data_o   read request (ignored while empty), head entry
//           count_o         entries held (AW+1 bits)
//           full_o, empty_o occupancy flags
// Rev     : 1.0  initial release
// ============================================================================
module alu_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are exactly AW bits, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; only entries below the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_sequencer
// Purpose : Queues packed ALU instructions, drives registered InA/InB/select
//           into an external likeALU, captures its combinational Out and
//           returns it over a valid/ready result port. Optional accumulate
//           mode substitutes the previous result for operand B.
// Ports   : in_valid/in_ready/in_instr      instruction input
//           alu_a/alu_b/alu_sel, alu_out    likeALU interface
//           res_valid/res_ready/res_data/res_op  result output
//           fifo_count, busy                status
// Rev     : 1.0  initial release
// ============================================================================
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_sel,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic [OP_W-1:0]    res_op,
  output logic [AW:0]        fifo_count,
  output logic               busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d, acc_q, acc_d;
  logic [OP_W-1:0]     res_op_q, res_op_d;
  logic                res_valid_q, res_valid_d;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [INSTR_W-1:0]  head;

  alu_instr_fifo #(.DEPTH(DEPTH), .AW(AW), .W(INSTR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  (in_instr),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready = !fifo_full;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_valid_d = res_valid_q;
    acc_d       = acc_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          alu_a_d   = head[A_LSB +: DATA_W];
          alu_sel_d = head[OP_LSB +: OP_W];
          alu_b_d   = head[USE_ACC_BIT] ? acc_q : head[B_LSB +: DATA_W];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        res_data_d  = alu_out;
        res_op_d    = alu_sel_q;
        acc_d       = alu_out;
        res_valid_d = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          // Issue the next queued op in the handshake cycle to sustain
          // one result every two cycles.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            alu_a_d   = head[A_LSB +: DATA_W];
            alu_sel_d = head[OP_LSB +: OP_W];
            alu_b_d   = head[USE_ACC_BIT] ? acc_q : head[B_LSB +: DATA_W];
            state_d   = ISSUE;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_valid_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_valid_q <= res_valid_d;
      acc_q       <= acc_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_op_sequencer
// Purpose : Self-checking bench for alu_op_sequencer with a behavioural
//           likeALU and an in-order result scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_instr;
  logic [4:0]  alu_a, alu_b, alu_out, res_data;
  logic [1:0]  alu_sel, res_op;
  logic        res_valid, res_ready;
  logic [2:0]  fifo_count;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [6:0] sb [$];      // {op, result}
  int         stamps [$];  // cycle numbers of result handshakes
  logic [4:0] model_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_op     (res_op),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a + b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // likeALU stand-in
  always_comb alu_out = alu_f(alu_sel, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare at the negedge before each handshake edge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      stamps.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_result", {25'd0, res_op, res_data}, 32'hFFFF_FFFF);
      end else begin
        logic [6:0] e;
        e = sb.pop_front();
        chk("result", {25'd0, res_op, res_data}, {25'd0, e});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic push(input logic use_acc, input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    logic [4:0] bb, r;
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_instr = {use_acc, op, a, b};
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
    else begin
      bb = use_acc ? model_acc : b;
      r  = alu_f(op, a, bb);
      model_acc = r;
      sb.push_back({op, r});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; res_ready = 1'b1; model_acc = '0;
    tick(2);
    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_outputs", {res_valid, res_data, res_op, alu_a, alu_b, alu_sel, fifo_count, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick(1);

    // 1: AND latency
    push(1'b0, 2'b00, 5'h1B, 5'h0F);           // accepted at edge k+1
    tick(1);                                    // after k+2
    chk("t1_valid_early", {31'd0, res_valid}, 32'd0);
    chk("t1_alu_inputs", {20'd0, alu_sel, alu_a, alu_b}, {20'd0, 2'b00, 5'h1B, 5'h0F});
    tick(1);                                    // after k+3
    chk("t1_valid_rise", {31'd0, res_valid}, 32'd1);
    drain();

    // 2: wrap / OR / XOR
    push(1'b0, 2'b01, 5'd31, 5'd1);
    push(1'b0, 2'b10, 5'h10, 5'h01);
    push(1'b0, 2'b11, 5'h15, 5'h1F);
    drain();

    // 3: accumulate chain 7, 9, 0x16
    push(1'b0, 2'b01, 5'd3, 5'd4);
    push(1'b1, 2'b01, 5'd2, 5'h1A);
    push(1'b1, 2'b11, 5'h1F, 5'h05);
    drain();
    chk("t3_acc_alu_b", {27'd0, alu_b}, 32'd9);

    // 4: stall with full FIFO
    res_ready = 1'b0;
    push(1'b0, 2'b01, 5'd1, 5'd1);
    push(1'b0, 2'b10, 5'h04, 5'h08);
    push(1'b0, 2'b11, 5'h0F, 5'h01);
    push(1'b0, 2'b00, 5'h1C, 5'h07);
    push(1'b0, 2'b01, 5'd20, 5'd20);
    chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t4_count", {29'd0, fifo_count}, 32'd4);
    tick(3);
    chk("t4_stalled_hold", {25'd0, res_valid, res_data, res_op}, {25'd0, 1'b1, 5'd2, 2'b01});
    chk("t4_count_hold", {29'd0, fifo_count}, 32'd4);
    res_ready = 1'b1;
    drain();
    chk("t4_drained_busy", {31'd0, busy}, 32'd0);

    // 5: back-to-back throughput
    stamps.delete();
    push(1'b0, 2'b00, 5'h1F, 5'h11);
    push(1'b0, 2'b01, 5'd9, 5'd8);
    push(1'b0, 2'b10, 5'h02, 5'h04);
    push(1'b0, 2'b11, 5'h0C, 5'h06);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    drain();
    chk("t5_busy_done", {31'd0, busy}, 32'd0);
    chk("t5_num_results", stamps.size(), 32'd4);
    if (stamps.size() == 4)
      for (int i = 1; i < 4; i++) chk("t5_spacing", stamps[i] - stamps[i-1], 32'd2);

    // 6: async reset during ISSUE with two queued
    push(1'b0, 2'b01, 5'd1, 5'd2);
    push(1'b0, 2'b01, 5'd3, 5'd4);
    push(1'b0, 2'b01, 5'd5, 5'd6);
    push(1'b0, 2'b01, 5'd7, 5'd8);
    chk("t6_pre_count", {29'd0, fifo_count}, 32'd2);
    rst = 1'b1;
    #1;
    chk("t6_async_outputs", {res_valid, res_data, res_op, alu_a, alu_b, alu_sel, fifo_count, busy}, 32'd0);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    model_acc = '0;
    @(negedge clk) rst = 1'b0;
    tick(1);
    push(1'b1, 2'b10, 5'h00, 5'h1F);            // acc must read 0 -> result 0
    push(1'b0, 2'b00, 5'h1F, 5'h03);
    drain();
    chk("t6_final_acc_b", {27'd0, alu_b}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
